// File: rtl/parking_pkg.sv
// Shared parking-system constants and helpers, used by the slot manager,
// the gate controllers and the display logic.
package parking_pkg;

   localparam int unsigned PARK_DEFAULT_SLOTS = 8;
   localparam int unsigned PARK_STAT_W        = 16;

   // Slot index width for a lot of n bays
   function automatic int unsigned park_idx_w(input int unsigned n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/lowest_free_finder.sv
// Combinational priority encoder: reports the lowest-index free bay.
module lowest_free_finder #(
   parameter int unsigned N_SLOTS = 8,
   parameter int unsigned IDX_W   = 3
) (
   input  logic [N_SLOTS-1:0] i_occupancy,
   output logic               o_found,
   output logic [IDX_W-1:0]   o_idx
);

   // Scan from the top down so the lowest free index is the last one written
   always_comb begin
      o_found = 1'b0;
      o_idx   = '0;
      for (int i = N_SLOTS - 1; i >= 0; i--) begin
         if (!i_occupancy[i]) begin
            o_found = 1'b1;
            o_idx   = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/parking_slot_manager.sv
// Parking slot allocator: registered occupancy map, lowest-free entry
// allocation, named-bay exit release, free count and full/empty flags.
// Optional feature macro: PARKING_STATS_EN adds saturating grant/reject
// counters (o_total_entries, o_total_rejects).
module parking_slot_manager
   import parking_pkg::*;
#(
   parameter int unsigned N_SLOTS = PARK_DEFAULT_SLOTS,
   parameter int unsigned IDX_W   = park_idx_w(N_SLOTS),
   parameter int unsigned CNT_W   = $clog2(N_SLOTS + 1)
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_entry_req,
   input  logic               i_exit_req,
   input  logic [IDX_W-1:0]   i_exit_slot,
   output logic               o_entry_grant,
   output logic               o_entry_reject,
   output logic [IDX_W-1:0]   o_entry_slot,
   output logic               o_exit_err,
   output logic [N_SLOTS-1:0] o_occupancy,
   output logic [CNT_W-1:0]   o_free_count,
   output logic               o_full,
`ifdef PARKING_STATS_EN
   output logic [PARK_STAT_W-1:0] o_total_entries,
   output logic [PARK_STAT_W-1:0] o_total_rejects,
`endif
   output logic               o_empty
);

   // Full index space of i_exit_slot, so out-of-range slots decode safely
   localparam int unsigned EXT_W = 1 << IDX_W;

   logic [N_SLOTS-1:0] r_occupancy;
   logic [CNT_W-1:0]   r_free;
   logic               r_full;
   logic               r_empty;
   logic [IDX_W-1:0]   r_entry_slot;
   logic               r_grant;
   logic               r_reject;
   logic               r_err;

   logic               w_found;
   logic [IDX_W-1:0]   w_idx;
   logic [EXT_W-1:0]   w_occ_ext;
   logic [EXT_W-1:0]   w_exit_mask_ext;
   logic               w_exit_in_range;
   logic               w_exit_valid;
   logic               w_grant;
   logic               w_reject;
   logic [N_SLOTS-1:0] w_occ_next;
   logic [CNT_W-1:0]   w_free_next;

   // Allocation always looks at the pre-exit map
   lowest_free_finder #(
      .N_SLOTS (N_SLOTS),
      .IDX_W   (IDX_W)
   ) u_finder (
      .i_occupancy (r_occupancy),
      .o_found     (w_found),
      .o_idx       (w_idx)
   );

   assign w_exit_in_range = ({1'b0, i_exit_slot} < (IDX_W + 1)'(N_SLOTS));
   assign w_exit_mask_ext = EXT_W'(1) << i_exit_slot;
   assign w_exit_valid    = i_exit_req && w_exit_in_range && w_occ_ext[i_exit_slot];
   assign w_grant         = i_entry_req && w_found;
   assign w_reject        = i_entry_req && !w_found;

   // Next occupancy map and free count from this cycle's requests
   always_comb begin
      w_occ_ext                = '0;
      w_occ_ext[N_SLOTS-1:0]   = r_occupancy;
      w_occ_next               = r_occupancy;
      if (w_grant) begin
         w_occ_next = w_occ_next | (N_SLOTS'(1) << w_idx);
      end
      if (w_exit_valid) begin
         w_occ_next = w_occ_next & ~w_exit_mask_ext[N_SLOTS-1:0];
      end
      w_free_next = r_free + CNT_W'(w_exit_valid) - CNT_W'(w_grant);
   end

   // Occupancy, counters, flags and response pulses
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_occupancy  <= '0;
         r_free       <= CNT_W'(N_SLOTS);
         r_full       <= 1'b0;
         r_empty      <= 1'b1;
         r_entry_slot <= '0;
         r_grant      <= 1'b0;
         r_reject     <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_occupancy <= w_occ_next;
         r_free      <= w_free_next;
         r_full      <= (w_free_next == '0);
         r_empty     <= (w_free_next == CNT_W'(N_SLOTS));
         r_grant     <= w_grant;
         r_reject    <= w_reject;
         r_err       <= i_exit_req && !w_exit_valid;
         if (w_grant) begin
            r_entry_slot <= w_idx;
         end
      end
   end

`ifdef PARKING_STATS_EN
   logic [PARK_STAT_W-1:0] r_total_entries;
   logic [PARK_STAT_W-1:0] r_total_rejects;

   // Saturating grant/reject counters
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_total_entries <= '0;
         r_total_rejects <= '0;
      end else begin
         if (w_grant && (r_total_entries != '1)) begin
            r_total_entries <= r_total_entries + 1'b1;
         end
         if (w_reject && (r_total_rejects != '1)) begin
            r_total_rejects <= r_total_rejects + 1'b1;
         end
      end
   end

   assign o_total_entries = r_total_entries;
   assign o_total_rejects = r_total_rejects;
`endif

   assign o_entry_grant  = r_grant;
   assign o_entry_reject = r_reject;
   assign o_entry_slot   = r_entry_slot;
   assign o_exit_err     = r_err;
   assign o_occupancy    = r_occupancy;
   assign o_free_count   = r_free;
   assign o_full         = r_full;
   assign o_empty        = r_empty;

endmodule

// File: tb/tb_parking_slot_manager.sv
// Scoreboard bench for parking_slot_manager: an 8-bay instance for the main
// scenarios and a 6-bay instance for out-of-range exit slots.
module tb_parking_slot_manager;

   typedef struct {
      string       name;
      logic        grant;
      logic        reject;
      logic        err;
      logic [2:0]  slot;
      logic [7:0]  occ;
      logic [3:0]  free;
      logic [15:0] ent;
      logic [15:0] rej;
   } exp_t;

   typedef struct {
      string      name;
      logic       err;
      logic [5:0] occ;
      logic [2:0] free;
   } exp6_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       entry_req = 1'b0;
   logic       exit_req = 1'b0;
   logic [2:0] exit_slot = 3'd0;
   logic       entry_grant, entry_reject, exit_err, full, empty;
   logic [2:0] entry_slot;
   logic [7:0] occupancy;
   logic [3:0] free_count;
`ifdef PARKING_STATS_EN
   logic [15:0] total_entries, total_rejects;
`endif

   logic       rst6 = 1'b1;
   logic       entry_req6 = 1'b0;
   logic       exit_req6 = 1'b0;
   logic [2:0] exit_slot6 = 3'd0;
   logic       grant6, reject6, err6, full6, empty6;
   logic [2:0] slot6;
   logic [5:0] occ6;
   logic [2:0] free6;
`ifdef PARKING_STATS_EN
   logic [15:0] tot_e6, tot_r6;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   exp_t  q[$];
   exp6_t q6[$];
   logic [15:0] exp_ent = 16'd0;
   logic [15:0] exp_rej = 16'd0;

   always #5 clk = ~clk;

   parking_slot_manager #(.N_SLOTS(8)) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_entry_req    (entry_req),
      .i_exit_req     (exit_req),
      .i_exit_slot    (exit_slot),
      .o_entry_grant  (entry_grant),
      .o_entry_reject (entry_reject),
      .o_entry_slot   (entry_slot),
      .o_exit_err     (exit_err),
      .o_occupancy    (occupancy),
      .o_free_count   (free_count),
      .o_full         (full),
`ifdef PARKING_STATS_EN
      .o_total_entries(total_entries),
      .o_total_rejects(total_rejects),
`endif
      .o_empty        (empty)
   );

   parking_slot_manager #(.N_SLOTS(6)) dut6 (
      .i_clk          (clk),
      .i_rst          (rst6),
      .i_entry_req    (entry_req6),
      .i_exit_req     (exit_req6),
      .i_exit_slot    (exit_slot6),
      .o_entry_grant  (grant6),
      .o_entry_reject (reject6),
      .o_entry_slot   (slot6),
      .o_exit_err     (err6),
      .o_occupancy    (occ6),
      .o_free_count   (free6),
      .o_full         (full6),
`ifdef PARKING_STATS_EN
      .o_total_entries(tot_e6),
      .o_total_rejects(tot_r6),
`endif
      .o_empty        (empty6)
   );

   // Drive one cycle of stimulus on the 8-bay instance and queue its expected response
   task automatic apply(input string nm, input logic r, input logic en, input logic ex,
                        input logic [2:0] es, input logic g, input logic rj, input logic e,
                        input logic [2:0] s, input logic [7:0] oc, input logic [3:0] fr);
      exp_t x;
      @(negedge clk);
      rst = r; entry_req = en; exit_req = ex; exit_slot = es;
      if (r) begin
         exp_ent = 16'd0; exp_rej = 16'd0;
      end else begin
         if (g && exp_ent != 16'hFFFF) exp_ent = exp_ent + 16'd1;
         if (rj && exp_rej != 16'hFFFF) exp_rej = exp_rej + 16'd1;
      end
      x.name = nm; x.grant = g; x.reject = rj; x.err = e; x.slot = s;
      x.occ = oc; x.free = fr; x.ent = exp_ent; x.rej = exp_rej;
      q.push_back(x);
   endtask

   task automatic apply6(input string nm, input logic r, input logic en, input logic ex,
                         input logic [2:0] es, input logic e, input logic [5:0] oc,
                         input logic [2:0] fr);
      exp6_t x;
      @(negedge clk);
      rst6 = r; entry_req6 = en; exit_req6 = ex; exit_slot6 = es;
      x.name = nm; x.err = e; x.occ = oc; x.free = fr;
      q6.push_back(x);
   endtask

   // Monitor: each edge the DUT presents a response; pop and compare
   always @(posedge clk) begin
      #1;
      if (q.size() > 0) begin
         exp_t x;
         logic ok;
         x = q.pop_front();
         ok = (entry_grant === x.grant) && (entry_reject === x.reject) &&
              (exit_err === x.err) && (entry_slot === x.slot) && (occupancy === x.occ) &&
              (free_count === x.free) && (full === (x.free == 4'd0)) &&
              (empty === (x.free == 4'd8));
`ifdef PARKING_STATS_EN
         ok = ok && (total_entries === x.ent) && (total_rejects === x.rej);
`endif
         n_cmp++;
         if (!ok) begin
            n_bad++;
            $display("FAIL %s: got g=%b r=%b e=%b slot=%0d occ=%h free=%0d full=%b empty=%b, want g=%b r=%b e=%b slot=%0d occ=%h free=%0d",
                     x.name, entry_grant, entry_reject, exit_err, entry_slot, occupancy,
                     free_count, full, empty, x.grant, x.reject, x.err, x.slot, x.occ, x.free);
         end
         n_cmp++;
         if (32'(free_count) != 8 - $countones(occupancy)) begin
            n_bad++;
            $display("FAIL %s popcount: got free=%0d occ=%h, want free=%0d", x.name,
                     free_count, occupancy, 8 - $countones(occupancy));
         end
      end
      if (q6.size() > 0) begin
         exp6_t y;
         y = q6.pop_front();
         n_cmp++;
         if (err6 !== y.err || occ6 !== y.occ || free6 !== y.free) begin
            n_bad++;
            $display("FAIL %s: got err=%b occ=%h free=%0d, want err=%b occ=%h free=%0d",
                     y.name, err6, occ6, free6, y.err, y.occ, y.free);
         end
      end
   end

   initial begin
      // Reset, including a request discarded by reset
      apply("reset1", 1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 4'd8);
      apply("reset2", 1, 1, 0, 0, 0, 0, 0, 0, 8'h00, 4'd8);
      // Fill the lot with entry_req held high
      for (int i = 0; i < 8; i++) begin
         apply("fill", 0, 1, 0, 0, 1, 0, 0, 3'(i), 8'((1 << (i + 1)) - 1), 4'(7 - i));
      end
      apply("fill_reject", 0, 1, 0, 0, 0, 1, 0, 3'd7, 8'hFF, 4'd0);
      // Exit and refill
      apply("exit5", 0, 0, 1, 5, 0, 0, 0, 3'd7, 8'hDF, 4'd1);
      apply("refill5", 0, 1, 0, 0, 1, 0, 0, 3'd5, 8'hFF, 4'd0);
      // Full: simultaneous entry and exit -> reject plus freed bay
      apply("full_sim", 0, 1, 1, 2, 0, 1, 0, 3'd5, 8'hFB, 4'd1);
      apply("bad_exit2", 0, 0, 1, 2, 0, 0, 1, 3'd5, 8'hFB, 4'd1);
      apply("exit7", 0, 0, 1, 7, 0, 0, 0, 3'd5, 8'h7B, 4'd2);
      apply("exit6", 0, 0, 1, 6, 0, 0, 0, 3'd5, 8'h3B, 4'd3);
      apply("exit5b", 0, 0, 1, 5, 0, 0, 0, 3'd5, 8'h1B, 4'd4);
      apply("exit4", 0, 0, 1, 4, 0, 0, 0, 3'd5, 8'h0B, 4'd5);
      apply("exit3", 0, 0, 1, 3, 0, 0, 0, 3'd5, 8'h03, 4'd6);
      apply("entry2", 0, 1, 0, 0, 1, 0, 0, 3'd2, 8'h07, 4'd5);
      // occupancy 07: entry + exit slot 1 -> grant slot 3, occ 0D
      apply("sim_07", 0, 1, 1, 1, 1, 0, 0, 3'd3, 8'h0D, 4'd5);
      apply("bad_exit1", 0, 0, 1, 1, 0, 0, 1, 3'd3, 8'h0D, 4'd5);
      apply("idle", 0, 0, 0, 0, 0, 0, 0, 3'd3, 8'h0D, 4'd5);
      // Reset mid-operation discards the concurrent exit
      apply("reset_mid", 1, 0, 1, 0, 0, 0, 0, 3'd0, 8'h00, 4'd8);
      apply("post_reset", 0, 1, 0, 0, 1, 0, 0, 3'd0, 8'h01, 4'd7);
      @(negedge clk);
      rst = 1'b0; entry_req = 1'b0; exit_req = 1'b0;

      // 6-bay instance: out-of-range exit slots
      apply6("n6_reset", 1, 0, 0, 0, 0, 6'h00, 3'd6);
      apply6("n6_entry", 0, 1, 0, 0, 0, 6'h01, 3'd5);
      apply6("n6_exit7", 0, 0, 1, 7, 1, 6'h01, 3'd5);
      apply6("n6_exit6", 0, 0, 1, 6, 1, 6'h01, 3'd5);
      apply6("n6_exit0", 0, 0, 1, 0, 0, 6'h00, 3'd6);
      @(negedge clk);
      entry_req6 = 1'b0; exit_req6 = 1'b0;

      repeat (3) @(posedge clk);
      #2;
      if (q.size() != 0 || q6.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: got %0d/%0d pending, want 0/0", q.size(), q6.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/parking_slot_manager.md
# parking_slot_manager

Parametrised slot-allocation engine for the parking system; the successor to the fixed 8-slot exit decoder. It holds a registered occupancy map of `N_SLOTS` bays and serves entry and exit requests each clock. On entry it allocates the lowest-index free bay. On exit it releases a named bay. It also maintains free count and full/empty flags. It sits between the gate controllers (entry/exit requests) and the display/billing logic (occupancy and counts).

## Interface
Parameters:
- `N_SLOTS`, default 8: number of bays, range 2..256.
- `IDX_W`, default `$clog2(N_SLOTS)`: slot index width, derived; not overridden.
- `CNT_W`, default `$clog2(N_SLOTS+1)`: free-count width, derived.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `entry_req`  in  1  car at entry gate; single-cycle pulse or level, sampled every edge.
- `exit_req`  in  1  car leaving.
- `exit_slot`  in  IDX_W  bay being released; valid with `exit_req`.
- `entry_grant`  out  1  one-cycle pulse: bay allocated.
- `entry_reject`  out  1  one-cycle pulse: lot full, no allocation.
- `entry_slot`  out  IDX_W  allocated bay index; valid while `entry_grant`=1, holds last value otherwise.
- `exit_err`  out  1  one-cycle pulse: `exit_slot` was free or ≥ `N_SLOTS`.
- `occupancy`  out  N_SLOTS  bit i = 1 when bay i is taken.
- `free_count`  out  CNT_W  number of free bays.
- `full`  out  1  `free_count` == 0.
- `empty`  out  1  `free_count` == `N_SLOTS`.

## Operation
- **Reset values:** `occupancy`=0, `free_count`=`N_SLOTS`, `empty`=1, `full`=0, `entry_slot`=0, and all pulses (`entry_grant`, `entry_reject`, `exit_err`)=0. Reset mid-operation discards any request sampled in the same cycle.
- **Entry, free bay available:** pick the lowest index i with `occupancy[i]`=0, set the bit, pulse `entry_grant`, and drive `entry_slot`=i.
- **Entry, lot full:** `occupancy` is unchanged and `entry_reject` pulses.
- **Exit, valid bay:** when `exit_slot` < `N_SLOTS` and its bit is 1, clear the bit.
- **Exit, invalid bay:** when `exit_slot` is out of range or the bay is already free, `exit_err` pulses and there is no state change.
- **Simultaneous entry and exit:** both are processed in the same cycle.
  - Allocation uses the pre-exit map, so a bay being released is never reallocated in the same cycle.
  - If the lot is full, the entry is rejected even though a bay frees that cycle.
  - `free_count` net change is 0 for a grant plus a valid exit.
- **`free_count` arithmetic:**
  - next = current + (valid exit) − (grant).
  - Kept as a counter; never recomputed by popcount.
  - Cannot underflow or overflow by construction.
  - Verification asserts `free_count` == `N_SLOTS` − popcount(`occupancy`) every cycle.
- **Request level:** a held-high `entry_req` allocates one bay per cycle until full, then rejects every cycle.

## Timing
- All outputs are registered.
- Request latency is 1 cycle: a request sampled at edge k produces grant/reject/err, the updated `occupancy`, `free_count`, `full` and `empty`, all visible after edge k.
- There is no handshake back-pressure; every request is answered on the next cycle.
- `full` and `empty` are registered alongside `free_count`; there is no combinational path from inputs to outputs.

## Configuration
- **`PARKING_STATS_EN` defined:** adds two outputs.
  - `total_entries`  out  16  count of grants.
  - `total_rejects`  out  16  count of rejects.
  - Both saturate at 16'hFFFF, reset to 0, and update on the same edge as the grant/reject.
- **`PARKING_STATS_EN` undefined:** the ports and counters are absent; all other behaviour is identical.

## Structure
- **Shared package `parking_pkg`:**
  - `PARK_DEFAULT_SLOTS` = 8.
  - `PARK_STAT_W` = 16.
  - Function `park_idx_w(n)` returning `$clog2(n)`, shared with the gate and display blocks.
- **Sub-module `lowest_free_finder`:**
  - Combinational priority encoder over the inverted occupancy.
  - Outputs `found` (1 bit) and `idx` (IDX_W).
  - Instantiated once.

## Test plan
Run with `N_SLOTS`=8 unless noted.
1. **Reset:** `rst`=1 for 2 cycles → `occupancy`=8'h00, `free_count`=8, `empty`=1, `full`=0, no pulses.
2. **Fill the lot:** `entry_req` held high 9 cycles → grants on slots 0..7 in order, `occupancy`=8'hFF, `full`=1, 9th cycle `entry_reject`=1.
3. **Exit and refill:** from full, exit slot 5 → `occupancy`=8'hDF, `free_count`=1; next entry → `entry_slot`=5, `full`=1.
4. **Bad exits:** exit slot 3 while free → `exit_err`=1, state unchanged; with `N_SLOTS`=6, `exit_slot`=7 → `exit_err`=1.
5. **Simultaneous events:**
   - `occupancy`=8'h07, entry + exit slot 1 together → grant slot 3, `occupancy`=8'h0D, `free_count` stays 5.
   - When full, simultaneous entry + exit → reject plus a freed bay.
6. **Stats (`PARKING_STATS_EN` defined):** scenario 2 → `total_entries`=8, `total_rejects`=1; a forced long run saturates at 16'hFFFF.
